// File: rtl/lab4_pkg.sv
// Shared definitions for the plot sequencer slice.
//   state_t       : sequencer states (IDLE -> CLEAR -> DRAW -> DONE)
//   SCREEN_W_DEF  : default visible columns
//   SCREEN_H_DEF  : default visible rows
package lab4_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/plot_clip.sv
// Combinational on-screen test for a single pixel.
//   x, y     : pixel coordinates
//   plot     : incoming plot strobe
//   plot_ok  : plot strobe, suppressed when the pixel lies off-screen
module plot_clip #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       plot,
    output logic       plot_ok
);

    assign plot_ok = plot && (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);

endmodule

// File: rtl/plot_sequencer.sv
// Clear-then-draw sequencer. Starts the clear engine, then the draw engine,
// and muxes whichever engine is active onto a registered VGA pixel port.
//   clk, rst                  : clock, synchronous active-high reset
//   start / done              : level request / completion (done held until start drops)
//   clr_start / clr_done      : handshake to the clear engine
//   clr_x/y/colour/plot       : clear engine pixel
//   drw_start / drw_done      : handshake to the draw engine
//   drw_x/y/colour/plot       : draw engine pixel
//   vga_x/y/colour/plot       : registered pixel, one cycle behind the source
// Build option: define PLOT_CLIP_EN to suppress plotting of off-screen pixels.
module plot_sequencer
    import lab4_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic       clr_start,
    input  logic       clr_done,
    input  logic [7:0] clr_x,
    input  logic [6:0] clr_y,
    input  logic [2:0] clr_colour,
    input  logic       clr_plot,
    output logic       drw_start,
    input  logic       drw_done,
    input  logic [7:0] drw_x,
    input  logic [6:0] drw_y,
    input  logic [2:0] drw_colour,
    input  logic       drw_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    state_t state, state_nxt;

    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;
    logic       sel_plot;
    logic       out_plot;

    // Next state. Once launched, the sequence ignores start until DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)    state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_done) state_nxt = ST_DRAW;
            ST_DRAW:  if (drw_done) state_nxt = ST_DONE;
            ST_DONE:  if (!start)   state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    assign clr_start = (state == ST_CLEAR);
    assign drw_start = (state == ST_DRAW);
    assign done      = (state == ST_DONE);

    // Source select. The inactive engine's plot is never looked at, and in
    // IDLE/DONE the coordinates recirculate so the VGA port holds its values.
    // The pixel that arrives with an engine's done is still selected because
    // the state only advances on that same edge.
    always_comb begin
        sel_x      = vga_x;
        sel_y      = vga_y;
        sel_colour = vga_colour;
        sel_plot   = 1'b0;
        case (state)
            ST_CLEAR: begin
                sel_x      = clr_x;
                sel_y      = clr_y;
                sel_colour = clr_colour;
                sel_plot   = clr_plot;
            end
            ST_DRAW: begin
                sel_x      = drw_x;
                sel_y      = drw_y;
                sel_colour = drw_colour;
                sel_plot   = drw_plot;
            end
            default: ;
        endcase
    end

`ifdef PLOT_CLIP_EN
    plot_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .x       (sel_x),
        .y       (sel_y),
        .plot    (sel_plot),
        .plot_ok (out_plot)
    );
`else
    assign out_plot = sel_plot;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_colour;
            vga_plot   <= out_plot;
        end
    end

endmodule

// File: tb/tb_plot_sequencer.sv
// Self-checking bench for plot_sequencer: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a phase-based model.
module tb_plot_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, clr_done, clr_plot, drw_done, drw_plot;
    logic [7:0] clr_x, drw_x;
    logic [6:0] clr_y, drw_y;
    logic [2:0] clr_colour, drw_colour;
    logic       done, clr_start, drw_start, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int total = 0;
    int bad   = 0;
    int n_clr, n_drw, n_done;

    // Reference: phase 0=idle 1=clear 2=draw 3=done, plus expected VGA pixel.
    int         m_ph = 0;
    logic [7:0] m_x = 0;
    logic [6:0] m_y = 0;
    logic [2:0] m_c = 0;
    logic       m_plot = 0;

    always #5 clk = ~clk;

    plot_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .clr_start(clr_start), .clr_done(clr_done),
        .clr_x(clr_x), .clr_y(clr_y), .clr_colour(clr_colour), .clr_plot(clr_plot),
        .drw_start(drw_start), .drw_done(drw_done),
        .drw_x(drw_x), .drw_y(drw_y), .drw_colour(drw_colour), .drw_plot(drw_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic zero_inputs();
        rst = 0; start = 0; clr_done = 0; clr_plot = 0; drw_done = 0; drw_plot = 0;
        clr_x = 0; clr_y = 0; clr_colour = 0; drw_x = 0; drw_y = 0; drw_colour = 0;
    endtask

    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
`ifdef PLOT_CLIP_EN
        return (x < 8'd160) && (y < 7'd120);
`else
        return 1'b1;
`endif
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        if (rst) begin
            m_ph = 0; m_x = 0; m_y = 0; m_c = 0; m_plot = 0;
        end else begin
            if (m_ph == 1) begin
                m_x = clr_x; m_y = clr_y; m_c = clr_colour;
                m_plot = clr_plot && on_screen(clr_x, clr_y);
                if (clr_done) m_ph = 2;
            end else if (m_ph == 2) begin
                m_x = drw_x; m_y = drw_y; m_c = drw_colour;
                m_plot = drw_plot && on_screen(drw_x, drw_y);
                if (drw_done) m_ph = 3;
            end else begin
                m_plot = 0;
                if (m_ph == 0 && start)       m_ph = 1;
                else if (m_ph == 3 && !start) m_ph = 0;
            end
        end
    endtask

    // One clock: inputs already applied, sample outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("clr_start",  {31'd0, clr_start}, {31'd0, m_ph == 1});
        chk("drw_start",  {31'd0, drw_start}, {31'd0, m_ph == 2});
        chk("done",       {31'd0, done},      {31'd0, m_ph == 3});
        chk("vga_plot",   {31'd0, vga_plot},  {31'd0, m_plot});
        chk("vga_x",      {24'd0, vga_x},     {24'd0, m_x});
        chk("vga_y",      {25'd0, vga_y},     {25'd0, m_y});
        chk("vga_colour", {29'd0, vga_colour},{29'd0, m_c});
        n_clr  += int'(clr_start);
        n_drw  += int'(drw_start);
        n_done += int'(done);
    endtask

    initial begin
        zero_inputs();
        @(negedge clk);

        // Reset state
        rst = 1; tick(); tick();
        chk("rst_vga_x", {24'd0, vga_x}, 32'd0);
        rst = 0;

        // Full sequence: clear 5 cycles, draw 3, done held while start=1
        n_clr = 0; n_drw = 0; n_done = 0;
        start = 1; tick();
        repeat (4) tick();
        clr_done = 1; tick(); clr_done = 0;
        repeat (2) tick();
        drw_done = 1; tick(); drw_done = 0;
        repeat (3) tick();
        chk("seq_clr_cycles", n_clr, 5);
        chk("seq_drw_cycles", n_drw, 3);
        chk("seq_done_held",  n_done, 4);
        start = 0; tick();
        chk("seq_back_idle",  {31'd0, done}, 32'd0);

        // Clear pixel forwarded one edge later, draw plot ignored
        start = 1; tick(); start = 0;
        clr_x = 8'd12; clr_y = 7'd34; clr_colour = 3'b000; clr_plot = 1;
        drw_x = 8'd1;  drw_y = 7'd1;  drw_plot = 1;
        chk("px_before", {31'd0, vga_plot}, 32'd0);
        tick();
        chk("px_x", {24'd0, vga_x}, 32'd12);
        chk("px_y", {25'd0, vga_y}, 32'd34);
        chk("px_plot", {31'd0, vga_plot}, 32'd1);
        clr_plot = 0; clr_done = 1; tick(); clr_done = 0;
        drw_plot = 0; drw_done = 1; tick(); drw_done = 0;
        tick();

        // Last draw pixel arriving with drw_done
        start = 1; tick(); clr_done = 1; tick(); clr_done = 0;
        drw_x = 8'd159; drw_y = 7'd119; drw_colour = 3'd5; drw_plot = 1; drw_done = 1;
        tick();
        drw_plot = 0; drw_done = 0;
        chk("last_x", {24'd0, vga_x}, 32'd159);
        chk("last_y", {25'd0, vga_y}, 32'd119);
        chk("last_plot", {31'd0, vga_plot}, 32'd1);
        chk("last_done", {31'd0, done}, 32'd1);
        start = 0; tick();

        // Reset in the middle of DRAW
        start = 1; tick(); clr_done = 1; tick(); clr_done = 0;
        drw_x = 8'd77; drw_y = 7'd55; drw_plot = 1; tick();
        rst = 1; drw_done = 1; tick(); rst = 0; drw_done = 0; drw_plot = 0; start = 0;
        chk("rstd_drw_start", {31'd0, drw_start}, 32'd0);
        chk("rstd_plot", {31'd0, vga_plot}, 32'd0);
        chk("rstd_x", {24'd0, vga_x}, 32'd0);
        chk("rstd_y", {25'd0, vga_y}, 32'd0);
        tick();

        // Off-screen clear pixel
        start = 1; tick(); start = 0;
        clr_x = 8'd160; clr_y = 7'd0; clr_plot = 1; tick(); clr_plot = 0;
        chk("clip_x", {24'd0, vga_x}, 32'd160);
`ifdef PLOT_CLIP_EN
        chk("clip_plot", {31'd0, vga_plot}, 32'd0);
`else
        chk("clip_plot", {31'd0, vga_plot}, 32'd1);
`endif
        clr_done = 1; tick(); clr_done = 0; drw_done = 1; tick(); drw_done = 0; tick();

        // start dropped mid-CLEAR: sequence completes, done pulses once
        n_done = 0;
        start = 1; tick(); start = 0;
        repeat (2) tick();
        clr_done = 1; tick(); clr_done = 0;
        drw_done = 1; tick(); drw_done = 0;
        repeat (3) tick();
        chk("drop_done_pulse", n_done, 1);
        chk("drop_idle", {31'd0, done | clr_start | drw_start}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            start      = ($urandom_range(0, 3) != 0);
            clr_done   = ($urandom_range(0, 4) == 0);
            drw_done   = ($urandom_range(0, 4) == 0);
            clr_plot   = $urandom_range(0, 1) == 1;
            drw_plot   = $urandom_range(0, 1) == 1;
            clr_x      = 8'($urandom_range(0, 255));
            clr_y      = 7'($urandom_range(0, 127));
            clr_colour = 3'($urandom_range(0, 7));
            drw_x      = 8'($urandom_range(0, 255));
            drw_y      = 7'($urandom_range(0, 127));
            drw_colour = 3'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
